cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Sequencing controller for the direct-mapped, write-back data cache: 64 lines × 8 words, 32-bit words.
- Holds the tag/valid/dirty store and decides hit or miss for each CPU access.
- On a miss it runs the line write-back engine (if the victim line is dirty), then the line allocate (refill) engine, using start/done handshakes.
- Drives cache data RAM address and write-enable for hit accesses; the data path muxing is external.

Parameters:
- TAG_W, 21, tag width = cpu_addr[31:11]
- INDEX_W, 6, line index = cpu_addr[10:5]
- OFFSET_W, 3, word-in-line = cpu_addr[4:2]

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; CPU holds it and addr/we stable until cpu_ready
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address
- cpu_ready  out  1  one-cycle pulse: access complete
- cpu_hit  out  1  valid with cpu_ready; 1 if the first compare hit
- hit_data_addr  out  9  cache data RAM address = {index, offset}
- hit_data_we  out  1  cache data RAM write strobe for store hits
- wb_start  out  1  one-cycle pulse to the write-back engine
- wb_addr  out  32  victim line base = {victim_tag, index, 5'b0}
- wb_done  in  1  one-cycle pulse from the write-back engine
- alloc_start  out  1  one-cycle pulse to the allocate engine
- alloc_addr  out  32  latched request address; stable from alloc_start until alloc_done
- alloc_done  in  1  one-cycle pulse from the allocate engine
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; all 64 valid and dirty bits cleared; latched address/we cleared. Reset mid-transaction aborts it (engines share rst); no cpu_ready is issued.
- State IDLE:
  - cpu_req=1 latches addr_q and we_q, then goes to COMPARE.
  - cpu_req is sampled only in IDLE.
- State COMPARE:
  - Reads tag store at addr_q index (combinational read).
  - hit = valid && tag == addr_q[31:11].
  - Hit → RESPOND. Miss with valid && dirty → WB_START. Otherwise miss → AL_START.
  - Sets miss_seen flag on a miss; the flag is cleared in IDLE.
- RESPOND (one cycle):
  - cpu_ready=1; cpu_hit = !miss_seen; hit_data_addr = {index, offset}; hit_data_we = we_q.
  - On a store, set dirty[index].
  - Next state IDLE.
- WB_START: wb_start=1 and wb_addr driven for one cycle; next state WB_WAIT.
- WB_WAIT: hold wb_addr; on wb_done go to AL_START.
- AL_START: alloc_start=1 for one cycle; next state AL_WAIT.
- AL_WAIT: hold alloc_addr; on alloc_done go to FILL.
- FILL: tag[index] ← addr_q tag, valid=1, dirty=0; next state COMPARE, which now hits.
- Latency:
  - Load/store hit: cpu_ready 2 cycles after the IDLE cycle that accepted the request.
  - Clean miss: 5 controller cycles plus allocate engine time.
  - Dirty miss: adds 2 cycles plus write-back time.
- wb_done/alloc_done outside their WAIT state are ignored.
- hit_data_we is asserted only in RESPOND; never during a refill.
- Address widths: hit_data_addr matches the allocate engine's cache layout (index<<3 + word). No arithmetic overflow is possible.

Decomposition:
- Package cache_pkg: TAG_W/INDEX_W/OFFSET_W, LINE_WORDS=8, the state enum (IDLE, COMPARE, RESPOND, WB_START, WB_WAIT, AL_START, AL_WAIT, FILL), and tag/index/offset field-extract functions.
- Sub-module tag_store: 64 × {valid, dirty, tag[20:0]} registers.
  - Async read port.
  - Sync write port.
  - set_dirty port.
  - Synchronous rst clears valid and dirty.

Test Plan:
- After rst, load 0x0000_0040 → no wb_start; alloc_start pulse with alloc_addr=0x40. Return alloc_done 10 cycles later → cpu_ready 3 cycles later (FILL, COMPARE, RESPOND), cpu_hit=0, hit_data_addr=16.
- Load 0x0000_0044 → cpu_ready 2 cycles after accept, cpu_hit=1, hit_data_addr=17, hit_data_we=0; no engine starts.
- Store 0x0000_0048 → hit, hit_data_we=1 for exactly one cycle, hit_data_addr=18; dirty[2] set.
- Load 0x0000_0840 (index 2, tag 1) → wb_start with wb_addr=0x40. After wb_done, alloc_start with alloc_addr=0x840. After alloc_done, cpu_ready with cpu_hit=0; dirty[2]=0.
- Assert rst during AL_WAIT → all outputs 0 next cycle. Then load 0x44 → misses (valid cleared), alloc_start reissued.
- Pulse alloc_done and wb_done while in IDLE and during RESPOND → no state change, no spurious cpu_ready or start pulses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-back cache controller.
package cache_pkg;

  localparam int TAG_W      = 21;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 3;
  localparam int LINE_WORDS = 8;
  localparam int NUM_LINES  = 1 << INDEX_W;

  // Byte address split into its cache fields.
  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [1:0]          byte_sel;
  } addr_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    RESPOND,
    WB_START,
    WB_WAIT,
    AL_START,
    AL_WAIT,
    FILL
  } state_e;

  // Base byte address of a line identified by tag and index.
  function automatic logic [31:0] line_base(input logic [TAG_W-1:0] tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {(OFFSET_W + 2){1'b0}}};
  endfunction

  // Word address inside the data RAM: index * LINE_WORDS + offset.
  function automatic logic [INDEX_W+OFFSET_W-1:0] data_addr(input logic [INDEX_W-1:0] index,
                                                            input logic [OFFSET_W-1:0] offset);
    return {index, offset};
  endfunction

endpackage

// File: rtl/tag_store.sv
// Tag/valid/dirty store: one entry per cache line, async read, sync fill and dirty-set.
module tag_store
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               fill_en,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               set_dirty,
  input  logic [INDEX_W-1:0] dirty_index
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];

  // Combinational read of the entry selected by the current request.
  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

  // Next-state for the store: a fill installs a clean valid line, a store hit marks it dirty.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (fill_en) begin
      valid_d[fill_index] = 1'b1;
      dirty_d[fill_index] = 1'b0;
      tag_d[fill_index]   = fill_tag;
    end
    if (set_dirty) begin
      dirty_d[dirty_index] = 1'b1;
    end
  end

  // Valid and dirty flags are cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag array storage.
  // NOTE: tags are not reset; a tag is only trusted when its valid bit is set.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Cache sequencing controller: hit/miss decision, write-back and refill handshakes, hit RAM strobes.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [31:0]                 cpu_addr,
  output logic                        cpu_ready,
  output logic                        cpu_hit,
  output logic [INDEX_W+OFFSET_W-1:0] hit_data_addr,
  output logic                        hit_data_we,
  output logic                        wb_start,
  output logic [31:0]                 wb_addr,
  input  logic                        wb_done,
  output logic                        alloc_start,
  output logic [31:0]                 alloc_addr,
  input  logic                        alloc_done,
  output logic                        busy
);

  state_e state_q, state_d;
  addr_t  addr_q, addr_d;
  logic   we_q, we_d;
  logic   miss_seen_q, miss_seen_d;

  logic                        cpu_ready_q, cpu_ready_d;
  logic                        cpu_hit_q, cpu_hit_d;
  logic [INDEX_W+OFFSET_W-1:0] hit_data_addr_q, hit_data_addr_d;
  logic                        hit_data_we_q, hit_data_we_d;
  logic                        wb_start_q, wb_start_d;
  logic [31:0]                 wb_addr_q, wb_addr_d;
  logic                        alloc_start_q, alloc_start_d;
  logic [31:0]                 alloc_addr_q, alloc_addr_d;
  logic                        busy_q, busy_d;

  logic             rd_valid;
  logic             rd_dirty;
  logic [TAG_W-1:0] rd_tag;
  logic             hit;

  tag_store u_tag_store (
    .clk         (clk),
    .rst         (rst),
    .rd_index    (addr_q.index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .fill_en     (state_q == FILL),
    .fill_index  (addr_q.index),
    .fill_tag    (addr_q.tag),
    .set_dirty   ((state_q == RESPOND) && we_q),
    .dirty_index (addr_q.index)
  );

  assign hit = rd_valid && (rd_tag == addr_q.tag);

  // Next state, request latching and the registered output values for the coming cycle.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    miss_seen_d  = miss_seen_q;
    wb_addr_d    = wb_addr_q;
    alloc_addr_d = alloc_addr_q;

    unique case (state_q)
      IDLE: begin
        miss_seen_d = 1'b0;
        if (cpu_req) begin
          addr_d  = addr_t'(cpu_addr);
          we_d    = cpu_we;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          state_d = RESPOND;
        end else begin
          miss_seen_d = 1'b1;
          if (rd_valid && rd_dirty) begin
            wb_addr_d = line_base(rd_tag, addr_q.index);
            state_d   = WB_START;
          end else begin
            alloc_addr_d = addr_q;
            state_d      = AL_START;
          end
        end
      end
      RESPOND:  state_d = IDLE;
      WB_START: state_d = WB_WAIT;
      WB_WAIT: begin
        if (wb_done) begin
          alloc_addr_d = addr_q;
          state_d      = AL_START;
        end
      end
      AL_START: state_d = AL_WAIT;
      AL_WAIT: begin
        if (alloc_done) state_d = FILL;
      end
      FILL:     state_d = COMPARE;
      default:  state_d = IDLE;
    endcase

    // Outputs are registered from the state being entered so they line up with that state.
    cpu_ready_d     = (state_d == RESPOND);
    cpu_hit_d       = (state_d == RESPOND) && !miss_seen_d;
    hit_data_addr_d = (state_d == RESPOND) ? data_addr(addr_q.index, addr_q.offset) : '0;
    hit_data_we_d   = (state_d == RESPOND) && we_q;
    wb_start_d      = (state_d == WB_START);
    alloc_start_d   = (state_d == AL_START);
    busy_d          = (state_d != IDLE);
  end

  // Controller state and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      we_q            <= 1'b0;
      miss_seen_q     <= 1'b0;
      cpu_ready_q     <= 1'b0;
      cpu_hit_q       <= 1'b0;
      hit_data_addr_q <= '0;
      hit_data_we_q   <= 1'b0;
      wb_start_q      <= 1'b0;
      wb_addr_q       <= '0;
      alloc_start_q   <= 1'b0;
      alloc_addr_q    <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      we_q            <= we_d;
      miss_seen_q     <= miss_seen_d;
      cpu_ready_q     <= cpu_ready_d;
      cpu_hit_q       <= cpu_hit_d;
      hit_data_addr_q <= hit_data_addr_d;
      hit_data_we_q   <= hit_data_we_d;
      wb_start_q      <= wb_start_d;
      wb_addr_q       <= wb_addr_d;
      alloc_start_q   <= alloc_start_d;
      alloc_addr_q    <= alloc_addr_d;
      busy_q          <= busy_d;
    end
  end

  assign cpu_ready     = cpu_ready_q;
  assign cpu_hit       = cpu_hit_q;
  assign hit_data_addr = hit_data_addr_q;
  assign hit_data_we   = hit_data_we_q;
  assign wb_start      = wb_start_q;
  assign wb_addr       = wb_addr_q;
  assign alloc_start   = alloc_start_q;
  assign alloc_addr    = alloc_addr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: driver predicts responses from a line-level cache model,
// monitor compares them when the DUT presents ready/start pulses, engines are emulated.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_hit;
  logic [8:0]  hit_data_addr;
  logic        hit_data_we;
  logic        wb_start;
  logic [31:0] wb_addr;
  logic        wb_done;
  logic        alloc_start;
  logic [31:0] alloc_addr;
  logic        alloc_done;
  logic        busy;

  cache_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_ready     (cpu_ready),
    .cpu_hit       (cpu_hit),
    .hit_data_addr (hit_data_addr),
    .hit_data_we   (hit_data_we),
    .wb_start      (wb_start),
    .wb_addr       (wb_addr),
    .wb_done       (wb_done),
    .alloc_start   (alloc_start),
    .alloc_addr    (alloc_addr),
    .alloc_done    (alloc_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         hit;
    logic [8:0] daddr;
    bit         we;
    int         drive_cyc;
  } resp_t;

  resp_t       exp_resp_q[$];
  logic [31:0] exp_wb_q[$];
  logic [31:0] exp_alloc_q[$];

  // Reference model: one entry per line.
  bit          m_valid [64];
  bit          m_dirty [64];
  int unsigned m_tag   [64];

  int n_cmp = 0;
  int n_err = 0;

  int alloc_delay_fix = 0;
  bit inject_spur = 0;
  int last_alloc_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cpu_ready"}, cpu_ready, 0);
    check({tag, "_cpu_hit"}, cpu_hit, 0);
    check({tag, "_hit_data_addr"}, hit_data_addr, 0);
    check({tag, "_hit_data_we"}, hit_data_we, 0);
    check({tag, "_wb_start"}, wb_start, 0);
    check({tag, "_wb_addr"}, wb_addr, 0);
    check({tag, "_alloc_start"}, alloc_start, 0);
    check({tag, "_alloc_addr"}, alloc_addr, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = 0;
    end
  endfunction

  // Predict the outcome of one access and advance the model.
  function automatic void predict(input logic [31:0] a, input bit w);
    int unsigned idx;
    int unsigned tg;
    bit          h;
    resp_t       r;
    idx = (a >> 5) & 63;
    tg  = a >> 11;
    h   = m_valid[idx] && (m_tag[idx] == tg);
    if (!h) begin
      if (m_valid[idx] && m_dirty[idx]) exp_wb_q.push_back((m_tag[idx] << 11) | (idx << 5));
      exp_alloc_q.push_back(a);
      m_tag[idx]   = tg;
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
    end
    if (w) m_dirty[idx] = 1;
    r.hit       = h;
    r.daddr     = 9'((a >> 2) & 511);
    r.we        = w;
    r.drive_cyc = cyc;
    exp_resp_q.push_back(r);
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) begin
      check("idle_timeout", busy, 0);
      finish_run();
    end
  endtask

  task automatic do_access(input logic [31:0] a, input bit w);
    bit got;
    wait_idle();
    predict(a, w);
    cpu_req  = 1;
    cpu_addr = a;
    cpu_we   = w;
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        got = 1;
        break;
      end
    end
    cpu_req = 0;
    if (!got) begin
      check("ready_timeout", got, 1);
      finish_run();
    end
  endtask

  // Start a miss, then assert reset while the controller waits for the allocate engine.
  task automatic reset_mid_alloc(input logic [31:0] a);
    bit got;
    wait_idle();
    alloc_delay_fix = 30;
    predict(a, 0);
    cpu_req  = 1;
    cpu_addr = a;
    cpu_we   = 0;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (alloc_start) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      check("alloc_start_timeout", got, 1);
      finish_run();
    end
    @(negedge clk);
    check("busy_in_al_wait", busy, 1);
    rst = 1;
    @(negedge clk);
    cpu_req = 0;
    check_zero("mid_rst");
    @(negedge clk);
    rst = 0;
    exp_resp_q.delete();
    exp_wb_q.delete();
    exp_alloc_q.delete();
    model_clear();
    alloc_delay_fix = 0;
  endtask

  // Write-back and allocate engine emulation, plus optional stray done pulses.
  int          wb_cnt = 0;
  int          alloc_cnt = 0;
  logic [31:0] wb_addr_cap = 0;
  logic [31:0] alloc_addr_cap = 0;
  initial begin
    wb_done    = 0;
    alloc_done = 0;
    forever begin
      @(negedge clk);
      wb_done    = 0;
      alloc_done = 0;
      if (rst) begin
        wb_cnt    = 0;
        alloc_cnt = 0;
      end else begin
        if (wb_cnt > 0) begin
          wb_cnt--;
          if (wb_cnt == 0) begin
            wb_done = 1;
            check("wb_addr_held", wb_addr, wb_addr_cap);
          end
        end
        if (alloc_cnt > 0) begin
          alloc_cnt--;
          if (alloc_cnt == 0) begin
            alloc_done = 1;
            last_alloc_done_cyc = cyc;
            check("alloc_addr_held", alloc_addr, alloc_addr_cap);
          end
        end
        if (wb_start) begin
          wb_cnt      = int'($urandom_range(1, 6));
          wb_addr_cap = wb_addr;
        end
        if (alloc_start) begin
          alloc_cnt      = (alloc_delay_fix > 0) ? alloc_delay_fix : int'($urandom_range(1, 6));
          alloc_addr_cap = alloc_addr;
        end
        if (inject_spur && (!busy || cpu_ready)) begin
          wb_done    = 1;
          alloc_done = 1;
        end
      end
    end
  end

  // Monitor: pop and compare whenever the DUT presents a response or an engine start.
  initial begin
    resp_t       r;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_ready) begin
          if (exp_resp_q.size() == 0) begin
            check("unexpected_ready", cpu_ready, 0);
          end else begin
            r = exp_resp_q.pop_front();
            check("cpu_hit", cpu_hit, r.hit);
            check("hit_data_addr", hit_data_addr, r.daddr);
            check("hit_data_we", hit_data_we, r.we);
            check("ready_latency", cyc, r.hit ? r.drive_cyc + 2 : last_alloc_done_cyc + 3);
          end
        end else if (hit_data_we) begin
          check("we_outside_respond", hit_data_we, 0);
        end
        if (wb_start) begin
          if (exp_wb_q.size() == 0) begin
            check("unexpected_wb_start", wb_start, 0);
          end else begin
            e = exp_wb_q.pop_front();
            check("wb_addr", wb_addr, e);
          end
        end
        if (alloc_start) begin
          if (exp_alloc_q.size() == 0) begin
            check("unexpected_alloc_start", alloc_start, 0);
          end else begin
            e = exp_alloc_q.pop_front();
            check("alloc_addr", alloc_addr, e);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios, stray done pulses, then randomized accesses.
  initial begin
    logic [31:0] a;
    rst      = 1;
    cpu_req  = 0;
    cpu_we   = 0;
    cpu_addr = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;

    alloc_delay_fix = 10;
    do_access(32'h0000_0040, 0);
    alloc_delay_fix = 0;
    do_access(32'h0000_0044, 0);
    do_access(32'h0000_0048, 1);
    do_access(32'h0000_0840, 0);
    do_access(32'h0000_0040, 0);

    reset_mid_alloc(32'h1000_0040);
    do_access(32'h0000_0044, 0);

    inject_spur = 1;
    do_access(32'h0000_0048, 1);
    repeat (4) @(negedge clk);
    do_access(32'h0000_0044, 0);
    do_access(32'h0000_2044, 1);
    repeat (4) @(negedge clk);
    inject_spur = 0;

    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 2) << 11) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      do_access(a, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    check("leftover_resp", exp_resp_q.size(), 0);
    check("leftover_wb", exp_wb_q.size(), 0);
    check("leftover_alloc", exp_alloc_q.size(), 0);
    finish_run();
  end

endmodule
